// File: rtl/alu_seq.sv
// Sequential N-bit ALU: single-cycle logic/shift/add/sub, iterative multiply and divide.
// Define ALU_SEVSEG_EN to add the seg output driving DIGITS active-low hex displays.
module alu_seq #(
  parameter int N = 4
`ifdef ALU_SEVSEG_EN
  , parameter int DIGITS = 4
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
`ifdef ALU_SEVSEG_EN
  , output logic [7*DIGITS-1:0] seg
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic              accept, iter_op, iter_last;

  logic [N-1:0]      a_p0, b_p0;
  logic [3:0]        op_p0;
  logic [2*N-1:0]    prod, mcand;
  logic [N-1:0]      mplier, quo, rem;
  logic [N:0]        rem_sh;
  logic              rem_ge;

  logic [N:0]        sum;
  logic [N-1:0]      diff;
  logic [N-1:0]      lo_nxt, hi_nxt;
  logic              c_nxt, v_nxt, load_result;

  assign accept    = (state == IDLE) && start;
  assign iter_op   = (op == 4'h8) || (((op == 4'h5) || (op == 4'h9)) && (b != '0));
  assign iter_last = (count == CW'(N));
  assign busy      = (state == EXEC) || (state == ITER);
  assign done      = (state == DONE);

  // Control: state register and iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        count <= '0;
      else if (state == ITER && !iter_last)
        count <= count + CW'(1);
    end
  end

  // ITER holds N iteration cycles plus one write-back cycle, giving N+2 edges start->done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = iter_op ? ITER : EXEC;
      EXEC:    state_nxt = DONE;
      ITER:    if (iter_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rem_sh = {rem, quo[N-1]};
  assign rem_ge = (rem_sh >= {1'b0, b_p0});

  // Stage p0: operand capture, then shift-add multiply and restoring divide
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= a;
      b_p0   <= b;
      op_p0  <= op;
      prod   <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      rem    <= '0;
      quo    <= a;
    end else if (state == ITER && !iter_last) begin
      prod   <= mplier[0] ? prod + mcand : prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_ge ? N'(rem_sh - {1'b0, b_p0}) : rem_sh[N-1:0];
      quo    <= {quo[N-2:0], rem_ge};
    end
  end

  assign sum  = {1'b0, a_p0} + {1'b0, b_p0};
  assign diff = a_p0 - b_p0;

  always_comb begin
    lo_nxt = '0;
    hi_nxt = '0;
    c_nxt  = 1'b0;
    v_nxt  = 1'b0;
    if (state == ITER) begin
      case (op_p0)
        4'h8: begin
          lo_nxt = prod[N-1:0];
          hi_nxt = prod[2*N-1:N];
          c_nxt  = |prod[2*N-1:N];
        end
        4'h9: begin
          lo_nxt = quo;
          hi_nxt = rem;
        end
        default: lo_nxt = rem;
      endcase
    end else begin
      case (op_p0)
        4'h0: lo_nxt = a_p0 & b_p0;
        4'h1: lo_nxt = a_p0 | b_p0;
        4'h2: lo_nxt = a_p0 ^ b_p0;
        4'h3: lo_nxt = a_p0 << b_p0;
        4'h4: lo_nxt = a_p0 >> b_p0;
        4'h5: begin
          lo_nxt = a_p0;
          v_nxt  = 1'b1;
        end
        4'h6: begin
          lo_nxt = sum[N-1:0];
          c_nxt  = sum[N];
          v_nxt  = (a_p0[N-1] == b_p0[N-1]) && (sum[N-1] != a_p0[N-1]);
        end
        4'h7: begin
          lo_nxt = diff;
          c_nxt  = (a_p0 >= b_p0);
          v_nxt  = (a_p0[N-1] != b_p0[N-1]) && (diff[N-1] != a_p0[N-1]);
        end
        4'h9: begin
          lo_nxt = '1;
          hi_nxt = a_p0;
          v_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_result = (state == EXEC) || (state == ITER && iter_last);

  // Stage p1: registered result and flags, held until the next completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_lo <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (load_result) begin
      result_lo <= lo_nxt;
      result_hi <= hi_nxt;
      flag_n    <= lo_nxt[N-1];
      flag_z    <= (lo_nxt == '0);
      flag_c    <= c_nxt;
      flag_v    <= v_nxt;
    end
  end

`ifdef ALU_SEVSEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] x);
    case (x)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [4*DIGITS+2*N-1:0] nib_all;
  assign nib_all = {{(4*DIGITS){1'b0}}, result_hi, result_lo};

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign seg[7*i +: 7] = hex7(nib_all[4*i +: 4]);
  end
`endif

endmodule
